// File: rtl/rv32i_types_pkg.sv
// Shared RV32I types for the arithmetic-unit issue path: ALU op and
// write-source encodings, the issue-buffer entry layout and a small
// wakeup helper.
package rv32i_types_pkg;

    localparam int REG_W  = 5;
    localparam int DATA_W = 32;

    typedef enum logic [3:0] {
        ALU_SLL  = 4'd0,
        ALU_SRL  = 4'd1,
        ALU_SRA  = 4'd2,
        ALU_ADD  = 4'd3,
        ALU_SUB  = 4'd4,
        ALU_AND  = 4'd5,
        ALU_OR   = 4'd6,
        ALU_XOR  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9
    } aluop_t;

    typedef enum logic [1:0] {
        W_SRC_ALU = 2'd0,
        W_SRC_CSR = 2'd1,
        W_SRC_IMM = 2'd2,
        W_SRC_PC  = 2'd3
    } w_src_t;

    typedef struct packed {
        logic              valid;
        aluop_t            aluop;
        w_src_t            w_src;
        logic [REG_W-1:0]  rd;
        logic [REG_W-1:0]  a_tag;
        logic [REG_W-1:0]  b_tag;
        logic              a_rdy;
        logic              b_rdy;
        logic [DATA_W-1:0] a_val;
        logic [DATA_W-1:0] b_val;
    } au_iq_entry_t;

    // A broadcast to x0 never wakes anything: x0 is hardwired and always ready.
    function automatic logic tag_hit(input logic wb_valid,
                                     input logic [REG_W-1:0] wb_rd,
                                     input logic [REG_W-1:0] tag);
        return wb_valid && (wb_rd != 5'd0) && (wb_rd == tag);
    endfunction

endpackage

// File: rtl/au_issue_buffer_if.sv
// Dispatch / writeback / issue bundle of the arithmetic-unit issue buffer.
interface au_issue_buffer_if #(
    parameter int DEPTH = 4
) ();
    logic                          flush;
    logic                          enq_valid;
    logic                          enq_ready;
    rv32i_types_pkg::aluop_t       enq_aluop;
    rv32i_types_pkg::w_src_t       enq_w_src;
    logic [4:0]                    enq_rd;
    logic [4:0]                    enq_a_tag;
    logic [4:0]                    enq_b_tag;
    logic                          enq_a_rdy;
    logic                          enq_b_rdy;
    logic [31:0]                   enq_a;
    logic [31:0]                   enq_b;
    logic                          wb_valid;
    logic [4:0]                    wb_rd;
    logic [31:0]                   wb_data;
    logic                          iss_ready;
    logic                          iss_valid;
    logic [31:0]                   iss_port_a;
    logic [31:0]                   iss_port_b;
    rv32i_types_pkg::aluop_t       iss_aluop;
    rv32i_types_pkg::w_src_t       iss_w_src;
    logic [4:0]                    iss_rd;
    logic [$clog2(DEPTH):0]        count;

    modport master (
        output flush, enq_valid, enq_aluop, enq_w_src, enq_rd, enq_a_tag, enq_b_tag,
               enq_a_rdy, enq_b_rdy, enq_a, enq_b, wb_valid, wb_rd, wb_data, iss_ready,
        input  enq_ready, iss_valid, iss_port_a, iss_port_b, iss_aluop, iss_w_src,
               iss_rd, count
    );

    modport slave (
        input  flush, enq_valid, enq_aluop, enq_w_src, enq_rd, enq_a_tag, enq_b_tag,
               enq_a_rdy, enq_b_rdy, enq_a, enq_b, wb_valid, wb_rd, wb_data, iss_ready,
        output enq_ready, iss_valid, iss_port_a, iss_port_b, iss_aluop, iss_w_src,
               iss_rd, count
    );
endinterface

// File: rtl/au_iq_wakeup.sv
// Per-entry operand wakeup: next ready bits and values of one entry's two
// source operands given the current writeback broadcast.
module au_iq_wakeup
    import rv32i_types_pkg::*;
(
    input  logic [4:0]  a_tag,
    input  logic [4:0]  b_tag,
    input  logic        a_rdy,
    input  logic        b_rdy,
    input  logic [31:0] a_val,
    input  logic [31:0] b_val,
    input  logic        wb_valid,
    input  logic [4:0]  wb_rd,
    input  logic [31:0] wb_data,
    output logic        a_rdy_nxt,
    output logic        b_rdy_nxt,
    output logic [31:0] a_val_nxt,
    output logic [31:0] b_val_nxt
);

    // Operand A: x0 is forced ready (value 0 if dispatch left it pending), otherwise capture a tag match.
    always_comb begin
        a_rdy_nxt = a_rdy;
        a_val_nxt = a_val;
        if (a_tag == 5'd0) begin
            a_rdy_nxt = 1'b1;
            a_val_nxt = a_rdy ? a_val : 32'h0000_0000;
        end else if (!a_rdy && tag_hit(wb_valid, wb_rd, a_tag)) begin
            a_rdy_nxt = 1'b1;
            a_val_nxt = wb_data;
        end else begin
            a_rdy_nxt = a_rdy;
            a_val_nxt = a_val;
        end
    end

    // Operand B: same rule, independent of A so both can wake together.
    always_comb begin
        b_rdy_nxt = b_rdy;
        b_val_nxt = b_val;
        if (b_tag == 5'd0) begin
            b_rdy_nxt = 1'b1;
            b_val_nxt = b_rdy ? b_val : 32'h0000_0000;
        end else if (!b_rdy && tag_hit(wb_valid, wb_rd, b_tag)) begin
            b_rdy_nxt = 1'b1;
            b_val_nxt = wb_data;
        end else begin
            b_rdy_nxt = b_rdy;
            b_val_nxt = b_val;
        end
    end

endmodule

// File: rtl/au_issue_buffer.sv
// In-order issue buffer in front of the arithmetic unit. Circular buffer of
// DEPTH entries; pending operands are captured from the writeback broadcast
// and the head issues once both operands are ready.
module au_issue_buffer
    import rv32i_types_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic             CLK,
    input  logic             nRST,
    au_issue_buffer_if.slave bus
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    au_iq_entry_t  entry_r     [DEPTH];
    au_iq_entry_t  entry_nxt_s [DEPTH];
    au_iq_entry_t  enq_entry_s;
    logic [PW-1:0] head_r, tail_r, head_nxt_s, tail_nxt_s;
    logic [CW-1:0] count_r, count_nxt_s;
    logic          enq_ready_s, iss_valid_s, do_enq_s, do_iss_s;

    logic          wk_a_rdy_s [DEPTH];
    logic          wk_b_rdy_s [DEPTH];
    logic [31:0]   wk_a_val_s [DEPTH];
    logic [31:0]   wk_b_val_s [DEPTH];
    logic          enq_a_rdy_s, enq_b_rdy_s;
    logic [31:0]   enq_a_val_s, enq_b_val_s;

    for (genvar i = 0; i < DEPTH; i++) begin : g_wake
        au_iq_wakeup u_wake (
            .a_tag     (entry_r[i].a_tag),
            .b_tag     (entry_r[i].b_tag),
            .a_rdy     (entry_r[i].a_rdy),
            .b_rdy     (entry_r[i].b_rdy),
            .a_val     (entry_r[i].a_val),
            .b_val     (entry_r[i].b_val),
            .wb_valid  (bus.wb_valid),
            .wb_rd     (bus.wb_rd),
            .wb_data   (bus.wb_data),
            .a_rdy_nxt (wk_a_rdy_s[i]),
            .b_rdy_nxt (wk_b_rdy_s[i]),
            .a_val_nxt (wk_a_val_s[i]),
            .b_val_nxt (wk_b_val_s[i])
        );
    end

    // The entry being enqueued sees the same-cycle broadcast too.
    au_iq_wakeup u_enq_wake (
        .a_tag     (bus.enq_a_tag),
        .b_tag     (bus.enq_b_tag),
        .a_rdy     (bus.enq_a_rdy),
        .b_rdy     (bus.enq_b_rdy),
        .a_val     (bus.enq_a),
        .b_val     (bus.enq_b),
        .wb_valid  (bus.wb_valid),
        .wb_rd     (bus.wb_rd),
        .wb_data   (bus.wb_data),
        .a_rdy_nxt (enq_a_rdy_s),
        .b_rdy_nxt (enq_b_rdy_s),
        .a_val_nxt (enq_a_val_s),
        .b_val_nxt (enq_b_val_s)
    );

    assign enq_ready_s = (count_r != FULL_CNT);
    assign iss_valid_s = entry_r[head_r].valid & entry_r[head_r].a_rdy & entry_r[head_r].b_rdy;
    assign do_enq_s    = bus.enq_valid & enq_ready_s;
    assign do_iss_s    = iss_valid_s & bus.iss_ready;

    assign bus.enq_ready  = enq_ready_s;
    assign bus.iss_valid  = iss_valid_s;
    assign bus.iss_port_a = entry_r[head_r].a_val;
    assign bus.iss_port_b = entry_r[head_r].b_val;
    assign bus.iss_aluop  = entry_r[head_r].aluop;
    assign bus.iss_w_src  = entry_r[head_r].w_src;
    assign bus.iss_rd     = entry_r[head_r].rd;
    assign bus.count      = count_r;

    // Assemble the incoming entry with its post-wakeup operand state.
    always_comb begin
        enq_entry_s       = '0;
        enq_entry_s.valid = 1'b1;
        enq_entry_s.aluop = bus.enq_aluop;
        enq_entry_s.w_src = bus.enq_w_src;
        enq_entry_s.rd    = bus.enq_rd;
        enq_entry_s.a_tag = bus.enq_a_tag;
        enq_entry_s.b_tag = bus.enq_b_tag;
        enq_entry_s.a_rdy = enq_a_rdy_s;
        enq_entry_s.b_rdy = enq_b_rdy_s;
        enq_entry_s.a_val = enq_a_val_s;
        enq_entry_s.b_val = enq_b_val_s;
    end

    // Next state: wakeup, then issue at head, enqueue at tail; flush overrides everything.
    always_comb begin
        entry_nxt_s = entry_r;
        head_nxt_s  = head_r;
        tail_nxt_s  = tail_r;
        count_nxt_s = count_r;
        for (int i = 0; i < DEPTH; i++) begin
            if (entry_r[i].valid) begin
                entry_nxt_s[i].a_rdy = wk_a_rdy_s[i];
                entry_nxt_s[i].b_rdy = wk_b_rdy_s[i];
                entry_nxt_s[i].a_val = wk_a_val_s[i];
                entry_nxt_s[i].b_val = wk_b_val_s[i];
            end else begin
                entry_nxt_s[i] = entry_r[i];
            end
        end
        if (do_iss_s) begin
            entry_nxt_s[head_r].valid = 1'b0;
            head_nxt_s = head_r + PW'(1);
        end else begin
            head_nxt_s = head_r;
        end
        if (do_enq_s) begin
            entry_nxt_s[tail_r] = enq_entry_s;
            tail_nxt_s = tail_r + PW'(1);
        end else begin
            tail_nxt_s = tail_r;
        end
        case ({do_enq_s, do_iss_s})
            2'b10:   count_nxt_s = count_r + CW'(1);
            2'b01:   count_nxt_s = count_r - CW'(1);
            default: count_nxt_s = count_r;
        endcase
        if (bus.flush) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_nxt_s[i].valid = 1'b0;
            end
            head_nxt_s  = '0;
            tail_nxt_s  = '0;
            count_nxt_s = '0;
        end else begin
            count_nxt_s = count_nxt_s;
        end
    end

    // State register; storage clears on reset so the issue outputs start at 0.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_r[i] <= '0;
            end
            head_r  <= '0;
            tail_r  <= '0;
            count_r <= '0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                entry_r[i] <= entry_nxt_s[i];
            end
            head_r  <= head_nxt_s;
            tail_r  <= tail_nxt_s;
            count_r <= count_nxt_s;
        end
    end

endmodule

// File: tb/tb_au_issue_buffer.sv
// Bench for au_issue_buffer: directed scenarios with literal expectations
// followed by random traffic, all checked against a queue-based model.
module tb_au_issue_buffer;
    import rv32i_types_pkg::*;

    localparam int DEPTH = 4;

    logic CLK = 1'b0;
    logic nRST = 1'b0;
    int   checks = 0;
    int   errors = 0;

    au_issue_buffer_if #(.DEPTH(DEPTH)) bus ();

    au_issue_buffer #(.DEPTH(DEPTH)) dut (
        .CLK  (CLK),
        .nRST (nRST),
        .bus  (bus)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic [3:0]  op;
        logic [1:0]  ws;
        logic [4:0]  rd;
        logic [4:0]  at;
        logic [4:0]  bt;
        logic        ar;
        logic        br;
        logic [31:0] a;
        logic [31:0] b;
    } m_t;

    m_t q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // An operand becomes ready when its register is written (x0 is always ready, value 0).
    function automatic m_t wake(input m_t e, input logic wv, input logic [4:0] wr, input logic [31:0] wd);
        m_t r = e;
        if (r.at == 5'd0) begin
            if (!r.ar) r.a = 32'd0;
            r.ar = 1'b1;
        end else if (!r.ar && wv && wr == r.at) begin
            r.ar = 1'b1;
            r.a  = wd;
        end
        if (r.bt == 5'd0) begin
            if (!r.br) r.b = 32'd0;
            r.br = 1'b1;
        end else if (!r.br && wv && wr == r.bt) begin
            r.br = 1'b1;
            r.b  = wd;
        end
        return r;
    endfunction

    function automatic logic head_ready();
        return (q.size() > 0) && q[0].ar && q[0].br;
    endfunction

    // Advance the model by one clock edge using the inputs the DUT sampled.
    task automatic model_step();
        logic iss;
        logic enq;
        m_t   n;
        if (!nRST || bus.flush) begin
            q.delete();
            return;
        end
        iss = head_ready() && bus.iss_ready;
        enq = bus.enq_valid && (q.size() != DEPTH);
        foreach (q[i]) q[i] = wake(q[i], bus.wb_valid, bus.wb_rd, bus.wb_data);
        if (iss) void'(q.pop_front());
        if (enq) begin
            n.op = bus.enq_aluop; n.ws = bus.enq_w_src; n.rd = bus.enq_rd;
            n.at = bus.enq_a_tag; n.bt = bus.enq_b_tag;
            n.ar = bus.enq_a_rdy; n.br = bus.enq_b_rdy;
            n.a  = bus.enq_a;     n.b  = bus.enq_b;
            q.push_back(wake(n, bus.wb_valid, bus.wb_rd, bus.wb_data));
        end
    endtask

    // Every-cycle comparison of the DUT against the model.
    always @(negedge CLK) begin
        if (nRST) begin
            check("iss_valid", 32'(bus.iss_valid), 32'(head_ready()));
            check("count", 32'(bus.count), 32'(q.size()));
            check("enq_ready", 32'(bus.enq_ready), 32'(q.size() != DEPTH));
            if (head_ready()) begin
                check("port_a", bus.iss_port_a, q[0].a);
                check("port_b", bus.iss_port_b, q[0].b);
                check("aluop", 32'(bus.iss_aluop), 32'(q[0].op));
                check("w_src", 32'(bus.iss_w_src), 32'(q[0].ws));
                check("rd", 32'(bus.iss_rd), 32'(q[0].rd));
            end
        end
    end

    task automatic cyc();
        @(posedge CLK);
        model_step();
        #1;
    endtask

    task automatic idle();
        bus.flush = 1'b0; bus.enq_valid = 1'b0;
        bus.enq_aluop = ALU_ADD; bus.enq_w_src = W_SRC_ALU; bus.enq_rd = 5'd0;
        bus.enq_a_tag = 5'd0; bus.enq_b_tag = 5'd0; bus.enq_a_rdy = 1'b1; bus.enq_b_rdy = 1'b1;
        bus.enq_a = 32'd0; bus.enq_b = 32'd0;
        bus.wb_valid = 1'b0; bus.wb_rd = 5'd0; bus.wb_data = 32'd0;
    endtask

    task automatic put(input logic [4:0] rd, input logic [4:0] at, input logic ar, input logic [31:0] a,
                       input logic [4:0] bt, input logic br, input logic [31:0] b);
        bus.enq_valid = 1'b1; bus.enq_aluop = ALU_ADD; bus.enq_w_src = W_SRC_ALU; bus.enq_rd = rd;
        bus.enq_a_tag = at; bus.enq_a_rdy = ar; bus.enq_a = a;
        bus.enq_b_tag = bt; bus.enq_b_rdy = br; bus.enq_b = b;
    endtask

    task automatic wb(input logic [4:0] rd, input logic [31:0] d);
        bus.wb_valid = 1'b1; bus.wb_rd = rd; bus.wb_data = d;
    endtask

    initial begin
        idle();
        bus.iss_ready = 1'b0;
        // Reset values
        repeat (2) cyc();
        check("rst_iss_valid", 32'(bus.iss_valid), 32'd0);
        check("rst_enq_ready", 32'(bus.enq_ready), 32'd1);
        check("rst_count", 32'(bus.count), 32'd0);
        check("rst_port_a", bus.iss_port_a, 32'd0);
        check("rst_port_b", bus.iss_port_b, 32'd0);
        check("rst_rd", 32'(bus.iss_rd), 32'd0);
        nRST = 1'b1;

        // Minimum latency: ready ADD issues one cycle after enqueue
        bus.iss_ready = 1'b1;
        put(5'd1, 5'd1, 1'b1, 32'd5, 5'd2, 1'b1, 32'd7);
        cyc(); idle();
        check("lat_valid", 32'(bus.iss_valid), 32'd1);
        check("lat_port_a", bus.iss_port_a, 32'd5);
        check("lat_port_b", bus.iss_port_b, 32'd7);
        check("lat_count1", 32'(bus.count), 32'd1);
        check("lat_enq_ready", 32'(bus.enq_ready), 32'd1);
        cyc();
        check("lat_count0", 32'(bus.count), 32'd0);

        // Fill to full, reject a fifth, then drain in order across the wrap
        bus.iss_ready = 1'b0;
        for (int k = 0; k < 4; k++) begin
            put(5'(k + 1), 5'd1, 1'b1, 32'(100 + k), 5'd2, 1'b1, 32'(200 + k));
            cyc();
        end
        put(5'd5, 5'd1, 1'b1, 32'd999, 5'd2, 1'b1, 32'd999);
        check("full_count", 32'(bus.count), 32'd4);
        check("full_enq_ready", 32'(bus.enq_ready), 32'd0);
        cyc(); idle();
        check("full_reject", 32'(bus.count), 32'd4);
        bus.iss_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            check("order_valid", 32'(bus.iss_valid), 32'd1);
            check("order_rd", 32'(bus.iss_rd), 32'(k + 1));
            check("order_a", bus.iss_port_a, 32'(100 + k));
            cyc();
        end
        check("drain_count", 32'(bus.count), 32'd0);

        // Blocked head waits for x3 while the younger entry is ready
        bus.iss_ready = 1'b0;
        put(5'd10, 5'd3, 1'b0, 32'd0, 5'd0, 1'b1, 32'd0);
        cyc();
        put(5'd11, 5'd1, 1'b1, 32'd1, 5'd2, 1'b1, 32'd2);
        cyc(); idle();
        bus.iss_ready = 1'b1;
        cyc();
        check("blk_valid", 32'(bus.iss_valid), 32'd0);
        check("blk_count", 32'(bus.count), 32'd2);
        wb(5'd3, 32'hDEAD);
        cyc(); idle();
        check("wake_valid", 32'(bus.iss_valid), 32'd1);
        check("wake_port_a", bus.iss_port_a, 32'hDEAD);
        check("wake_rd", 32'(bus.iss_rd), 32'd10);
        cyc();
        check("next_rd", 32'(bus.iss_rd), 32'd11);
        check("next_valid", 32'(bus.iss_valid), 32'd1);
        cyc();

        // Wakeup on the enqueue path
        put(5'd12, 5'd1, 1'b1, 32'd3, 5'd9, 1'b0, 32'd0);
        wb(5'd9, 32'h10);
        cyc(); idle();
        check("enqwk_valid", 32'(bus.iss_valid), 32'd1);
        check("enqwk_port_b", bus.iss_port_b, 32'h10);
        cyc();

        // Broadcast to x0 changes nothing; x0 operand counts as ready
        bus.iss_ready = 1'b0;
        put(5'd13, 5'd0, 1'b1, 32'd0, 5'd4, 1'b0, 32'd0);
        cyc(); idle();
        wb(5'd0, 32'hFFFF);
        cyc(); idle();
        check("x0_wait", 32'(bus.iss_valid), 32'd0);
        wb(5'd4, 32'h44);
        cyc(); idle();
        check("x0_valid", 32'(bus.iss_valid), 32'd1);
        check("x0_port_a", bus.iss_port_a, 32'd0);
        check("x0_port_b", bus.iss_port_b, 32'h44);
        bus.iss_ready = 1'b1;
        cyc();

        // Flush beats a simultaneous enqueue
        bus.iss_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            put(5'(20 + k), 5'd1, 1'b1, 32'(k), 5'd2, 1'b1, 32'(k));
            cyc();
        end
        put(5'd23, 5'd1, 1'b1, 32'd9, 5'd2, 1'b1, 32'd9);
        bus.flush = 1'b1;
        cyc(); idle();
        check("flush_count", 32'(bus.count), 32'd0);
        check("flush_valid", 32'(bus.iss_valid), 32'd0);
        check("flush_enq_ready", 32'(bus.enq_ready), 32'd1);

        // Asynchronous reset mid-stream
        put(5'd30, 5'd1, 1'b1, 32'h55, 5'd2, 1'b1, 32'h66);
        cyc(); idle();
        cyc();
        #2;
        nRST = 1'b0;
        q.delete();
        #1;
        check("arst_valid", 32'(bus.iss_valid), 32'd0);
        check("arst_count", 32'(bus.count), 32'd0);
        check("arst_enq_ready", 32'(bus.enq_ready), 32'd1);
        check("arst_port_a", bus.iss_port_a, 32'd0);
        cyc(); cyc();
        nRST = 1'b1;

        // Random traffic against the model
        for (int n = 0; n < 3000; n++) begin
            logic [4:0] at;
            logic [4:0] bt;
            at = 5'($urandom_range(0, 7));
            bt = 5'($urandom_range(0, 7));
            bus.enq_valid = ($urandom_range(0, 9) < 6);
            bus.enq_aluop = aluop_t'($urandom_range(0, 9));
            bus.enq_w_src = w_src_t'($urandom_range(0, 3));
            bus.enq_rd    = 5'($urandom_range(0, 31));
            bus.enq_a_tag = at;
            bus.enq_b_tag = bt;
            bus.enq_a_rdy = (at == 5'd0) ? 1'b1 : 1'($urandom_range(0, 1));
            bus.enq_b_rdy = (bt == 5'd0) ? 1'b1 : 1'($urandom_range(0, 1));
            bus.enq_a     = $urandom;
            bus.enq_b     = $urandom;
            bus.wb_valid  = ($urandom_range(0, 9) < 4);
            bus.wb_rd     = 5'($urandom_range(0, 7));
            bus.wb_data   = $urandom;
            bus.iss_ready = ($urandom_range(0, 9) < 7);
            bus.flush     = ($urandom_range(0, 39) == 0);
            cyc();
        end
        idle();
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/au_issue_buffer.md
# au_issue_buffer

In-order issue buffer that feeds the arithmetic unit. It sits between dispatch and the arithmetic unit's input side (port_a, port_b, aluop, w_src). It holds up to DEPTH decoded ALU/CSR operations. Source operands that are still pending are captured from the writeback broadcast, and the head entry is issued once both of its operands are ready and the arithmetic-unit stage can accept it.

## Interface
- DEPTH, 4, number of entries; power of two, at least 2.
- CLK  in  1  clock; all state updates on the rising edge.
- nRST  in  1  asynchronous active-low reset.
- flush  in  1  synchronous clear of all entries (branch mispredict or exception).
- enq_valid  in  1  dispatch presents an operation.
- enq_ready  out  1  high when an entry is free; it does not depend on enq_valid.
- enq_aluop  in  aluop_t  ALU operation.
- enq_w_src  in  w_src_t  write-source select, forwarded unchanged.
- enq_rd  in  5  destination register.
- enq_a_tag, enq_b_tag  in  5 each  source register of each pending operand.
- enq_a_rdy, enq_b_rdy  in  1 each  operand value already valid.
- enq_a, enq_b  in  32 each  operand values; ignored while the matching rdy bit is 0.
- wb_valid  in  1  writeback broadcast valid.
- wb_rd  in  5  broadcast destination.
- wb_data  in  32  broadcast value.
- iss_ready  in  1  arithmetic-unit stage accepts an operation this cycle.
- iss_valid  out  1  head entry is issuing.
- iss_port_a, iss_port_b  out  32 each  operand values.
- iss_aluop  out  aluop_t  operation.
- iss_w_src  out  w_src_t  write-source select.
- iss_rd  out  5  destination register.
- count  out  $clog2(DEPTH)+1  current occupancy.

## Operation
- The buffer is a circular buffer with head and tail pointers of width $clog2(DEPTH) and a separate occupancy counter.
- Enqueue:
  - An enqueue happens when enq_valid && enq_ready.
  - The operation is written at the tail and the tail advances modulo DEPTH.
- Wakeup:
  - When wb_valid is high and wb_rd != 0, every valid entry whose operand is not ready and whose tag == wb_rd takes wb_data and sets that operand's ready bit. Both operands of one entry can wake in the same cycle.
  - A wakeup that matches an operation enqueueing in the same cycle is applied to the new entry.
  - Tag 0 is always ready. Dispatch sets rdy=1 for x0 operands, and the buffer forces rdy when the tag is 0.
- Issue:
  - iss_valid = head entry valid && a_rdy && b_rdy. It is combinational from the registered state only; there is no same-cycle wb bypass to the issue outputs.
  - An operation issues when iss_valid && iss_ready; the head then advances.
  - Issue is strictly in order. A blocked head stalls all younger entries.
- Occupancy: enqueue and issue in the same cycle leave count unchanged. Enqueue into a full buffer is impossible because enq_ready = (count != DEPTH).
- Flush:
  - Clears all valid bits, both pointers and count on the next edge.
  - Flush takes priority over a simultaneous enqueue, issue or wakeup.
- The iss_* data outputs are don't-care while iss_valid is 0, but they are driven from the head entry, with no X.

## Timing
- Reset values: all valid bits 0, head = tail = 0, count = 0, iss_valid = 0, enq_ready = 1, and the iss_* data outputs are 0 because the storage resets to 0.
- Minimum latency: an operation enqueued with both operands ready into an empty buffer is visible as iss_valid one cycle after enqueue.
- An operand woken at edge N lets the entry issue in cycle N+1 if it is at the head.
- A slot freed by issue at edge N shows enq_ready = 1 from cycle N+1 onward. Space freed in the same cycle is not passed back combinationally.
- If nRST asserts mid-operation, all state is cleared immediately regardless of CLK.

## Structure
- The entry struct (valid, aluop, w_src, rd, a/b tag, a/b rdy, a/b value) is typedef'd as au_iq_entry_t in rv32i_types_pkg next to aluop_t and w_src_t.
- One natural sub-module, au_iq_wakeup. It is a combinational comparator that, for one entry, produces the next operand ready bits and values from the wb_* inputs. It is instantiated per entry and also on the enqueue path.

## Test plan
- Reset, then enqueue ADD with a=5, b=7 (both ready) with iss_ready=1: iss_valid rises one cycle later with port_a=5 and port_b=7; count goes 1→0; enq_ready stays 1.
- Enqueue 4 operations with iss_ready=0: count=4 and enq_ready=0; the 5th enq_valid is not accepted. Raise iss_ready: operations issue in enqueue order, one per cycle, and the pointers wrap with no loss.
- Head waits on a_tag=x3 while entry 2 is ready: nothing issues. wb_valid with wb_rd=3 and wb_data=0xDEAD: the head issues the next cycle with port_a=0xDEAD, followed by entry 2.
- Enqueue with b_tag=x9 pending in the same cycle as wb_rd=9 and wb_data=0x10: the entry issues one cycle later with port_b=0x10.
- Broadcast with wb_rd=0 and wb_data=0xFFFF while an entry has tag x0: no value change, and that operand is treated as ready.
- 3 entries queued plus a simultaneous enq_valid and flush: the next cycle count=0, iss_valid=0 and enq_ready=1. Also assert nRST mid-stream: all outputs return to their reset values asynchronously.
